q_update: RTL and testbench

Q-value update engine. Consumes each transition (state, action, next state) emitted by the agent, scans the Q-table row of the next state for its maximum, and writes back the temporal-difference update for Q(state, action). Also returns the greedy action for the next state so the agent can select it. Sits directly downstream of the agent in the learning loop.

---
 rtl/q_update_pkg.sv | 9 +
 rtl/q_update_q_table.sv | 34 +++
 rtl/q_update.sv | 114 +++++++++++
 tb/tb_q_update.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/q_update_pkg.sv
// q_update_pkg: shared FSM states, Q fixed-point type and range constants for the Q-value update engine
package q_update_pkg;
  localparam int Q_W = 16;
  localparam int FRAC_BITS = 8;
  typedef logic signed [Q_W-1:0] q_t;
  localparam q_t Q_MAX = 16'sh7fff;
  localparam q_t Q_MIN = 16'sh8000;
  typedef enum logic [1:0] {IDLE, SCAN, CALC, WRITE} state_t;
endpackage

// File: rtl/q_update_q_table.sv
// q_table: STATES x ACTIONS Q-value register file, two combinational read ports and one synchronous write port
module q_table
  import q_update_pkg::*;
#(
  parameter int STATES = 16,
  parameter int ACTIONS = 4,
  parameter int STATES_WIDTH = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int Q_WIDTH = Q_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [STATES_WIDTH-1:0]   w_st,
  input  logic [ACTIONS_WIDTH-1:0]  w_at,
  input  logic signed [Q_WIDTH-1:0] w_data,
  input  logic [STATES_WIDTH-1:0]   scan_st,
  input  logic [ACTIONS_WIDTH-1:0]  scan_at,
  output logic signed [Q_WIDTH-1:0] scan_q,
  input  logic [STATES_WIDTH-1:0]   calc_st,
  input  logic [ACTIONS_WIDTH-1:0]  calc_at,
  output logic signed [Q_WIDTH-1:0] calc_q
);
  logic signed [Q_WIDTH-1:0] q [STATES][ACTIONS];
  assign scan_q = q[scan_st][scan_at];
  assign calc_q = q[calc_st][calc_at];
  // clear every entry on reset, otherwise single-entry write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < STATES; s++)
        for (int a = 0; a < ACTIONS; a++)
          q[s][a] <= '0;
    end else if (we) q[w_st][w_at] <= w_data;
endmodule

// File: rtl/q_update.sv
// q_update: TD Q-value update engine (scan next-state row for max, compute and write back Q(st,at)); Q_SATURATE_EN clamps the result instead of wrapping
module q_update
  import q_update_pkg::*;
#(
  parameter int STATES = 16,
  parameter int ACTIONS = 4,
  parameter int STATES_WIDTH = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int Q_WIDTH = Q_W,
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [STATES_WIDTH-1:0]   i_st,
  input  logic [ACTIONS_WIDTH-1:0]  i_at,
  input  logic [STATES_WIDTH-1:0]   i_next_st,
  input  logic signed [Q_WIDTH-1:0] i_reward,
  input  logic                      i_terminal,
  output logic                      o_ready,
  output logic                      o_done,
  output logic [ACTIONS_WIDTH-1:0]  o_at_max,
  output logic signed [Q_WIDTH-1:0] o_q_new
);
  localparam int EW = Q_WIDTH + 3;
`ifdef Q_SATURATE_EN
  localparam logic signed [EW-1:0] SAT_MAX = {4'b0000, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {4'b1111, {(Q_WIDTH-1){1'b0}}};
`endif
  state_t                    state;
  logic [STATES_WIDTH-1:0]   st, next_st;
  logic [ACTIONS_WIDTH-1:0]  at, idx, arg;
  logic signed [Q_WIDTH-1:0] reward, best, q_new_r, scan_q, calc_q, new_q;
  logic                      terminal;
  logic signed [EW-1:0]      m, gm, qx, delta, sum;

  assign o_ready = state == IDLE;

  q_table #(
    .STATES(STATES), .ACTIONS(ACTIONS), .STATES_WIDTH(STATES_WIDTH),
    .ACTIONS_WIDTH(ACTIONS_WIDTH), .Q_WIDTH(Q_WIDTH)
  ) u_table (
    .clk(clk), .rst_n(rst_n),
    .we(state == WRITE), .w_st(st), .w_at(at), .w_data(q_new_r),
    .scan_st(next_st), .scan_at(idx), .scan_q(scan_q),
    .calc_st(st), .calc_at(at), .calc_q(calc_q)
  );

  // TD update in widened signed arithmetic; every concat is cast signed so the shifts stay arithmetic
  always_comb begin
    m = terminal ? '0 : signed'({{3{best[Q_WIDTH-1]}}, best});
    gm = m - (m >>> GAMMA_SHIFT);
    qx = signed'({{3{calc_q[Q_WIDTH-1]}}, calc_q});
    delta = signed'({{3{reward[Q_WIDTH-1]}}, reward}) + gm - qx;
    sum = qx + (delta >>> ALPHA_SHIFT);
`ifdef Q_SATURATE_EN
    new_q = sum > SAT_MAX ? Q_WIDTH'(SAT_MAX) : sum < SAT_MIN ? Q_WIDTH'(SAT_MIN) : Q_WIDTH'(sum);
`else
    new_q = Q_WIDTH'(sum);
`endif
  end

  // control FSM: capture, scan row for argmax (ties keep lowest index), compute, write back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      st       <= '0;
      at       <= '0;
      next_st  <= '0;
      reward   <= '0;
      terminal <= 1'b0;
      idx      <= '0;
      arg      <= '0;
      best     <= '0;
      q_new_r  <= '0;
      o_done   <= 1'b0;
      o_at_max <= '0;
      o_q_new  <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          st       <= i_st;
          at       <= i_at;
          next_st  <= i_next_st;
          reward   <= i_reward;
          terminal <= i_terminal;
          idx      <= '0;
          arg      <= '0;
          best     <= {1'b1, {(Q_WIDTH-1){1'b0}}};
          state    <= SCAN;
        end
        SCAN: begin
          if (scan_q > best) begin
            best <= scan_q;
            arg  <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == ACTIONS_WIDTH'(ACTIONS - 1)) state <= CALC;
        end
        CALC: begin
          q_new_r <= new_q;
          o_done  <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          o_q_new  <= q_new_r;
          o_at_max <= arg;
          o_done   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_q_update.sv
// tb_q_update: scoreboard bench for q_update against a reference TD-update model
module tb_q_update;
  import q_update_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_terminal = 1'b0;
  logic [3:0] i_st = '0, i_next_st = '0;
  logic [1:0] i_at = '0;
  logic signed [15:0] i_reward = '0;
  logic o_ready, o_done;
  logic [1:0] o_at_max;
  logic signed [15:0] o_q_new;
  int passed = 0, total = 0, cyc = 0, n_push = 0, n_done = 0, nz = 0;
  int mq [16][4];
  typedef struct {int a; int q; int c;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  q_update u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_st(i_st), .i_at(i_at),
    .i_next_st(i_next_st), .i_reward(i_reward), .i_terminal(i_terminal),
    .o_ready(o_ready), .o_done(o_done), .o_at_max(o_at_max), .o_q_new(o_q_new)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clear_model();
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 4; a++)
        mq[s][a] = 0;
  endtask

  // wait for ready, predict the result, drive one transition for one cycle
  task automatic send(input int s, input int a, input int n, input int r, input int t, input bit push = 1'b1);
    exp_t e;
    int best, m, gm, d, nv;
    for (int k = 0; k < 50 && !o_ready; k++) @(negedge clk);
    check("ready_wait", int'(o_ready), 1);
    if (push) begin
      best = -32768;
      e.a = 0;
      for (int k = 0; k < 4; k++)
        if (mq[n][k] > best) begin
          best = mq[n][k];
          e.a = k;
        end
      m = t != 0 ? 0 : best;
      gm = m - (m >>> 3);
      d = r + gm - mq[s][a];
      nv = mq[s][a] + (d >>> 1);
`ifdef Q_SATURATE_EN
      nv = nv > int'(Q_MAX) ? int'(Q_MAX) : nv < int'(Q_MIN) ? int'(Q_MIN) : nv;
`else
      nv = int'(q_t'(nv));
`endif
      mq[s][a] = nv;
      e.q = nv;
      e.c = cyc;
      sb.push_back(e);
      n_push++;
    end
    i_st = 4'(s);
    i_at = 2'(a);
    i_next_st = 4'(n);
    i_reward = 16'(r);
    i_terminal = t != 0;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (sb.size() > 0 || !o_ready); k++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // pop on each done pulse; results are visible one cycle later
  always @(negedge clk)
    if (rst_n && o_done) begin
      n_done++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc - mon_e.c, 6);
        @(negedge clk);
        check("q_new", int'(o_q_new), mon_e.q);
        check("at_max", int'(o_at_max), mon_e.a);
        check("done_pulse", int'(o_done), 0);
        check("ready_after", int'(o_ready), 1);
      end
    end

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_ready", int'(o_ready), 1);
    check("rst_done", int'(o_done), 0);
    check("rst_q_new", int'(o_q_new), 0);
    check("rst_at_max", int'(o_at_max), 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(2, 1, 5, 1 <<< FRAC_BITS, 0);
    drain();
    check("t1_q", int'(o_q_new), 128);
    check("t1_tbl", int'(u_dut.u_table.q[2][1]), 128);
    check("t1_at", int'(o_at_max), 0);
    send(1, 0, 2, 0, 0);
    drain();
    check("t2_q", int'(o_q_new), 56);
    check("t2_at", int'(o_at_max), 1);
    send(1, 0, 2, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    nz = 0;
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 4; a++)
        if (u_dut.u_table.q[s][a] != 0) nz++;
    check("mid_rst_tbl", nz, 0);
    check("mid_rst_q_new", int'(o_q_new), 0);
    rst_n = 1'b1;
    check("mid_rst_ready", int'(o_ready), 1);
    @(negedge clk);
    send(2, 1, 5, 256, 0);
    send(1, 0, 2, 0, 1);
    drain();
    check("term_q", int'(o_q_new), 0);
    check("term_at", int'(o_at_max), 1);
    for (int k = 0; k < 40 && mq[3][0] != 32000; k++)
      send(3, 0, 3, mq[3][0] == 31999 ? 32001 : 32000, 1);
    drain();
    check("pre_sat_tbl", int'(u_dut.u_table.q[3][0]), 32000);
    send(3, 0, 3, 32767, 0);
    drain();
`ifdef Q_SATURATE_EN
    check("sat_q", int'(o_q_new), 32767);
`else
    check("wrap_q", int'(o_q_new), -19153);
`endif
    send(4, 2, 7, -300, 0);
    i_st = 4'd5;
    i_at = 2'd3;
    i_reward = 16'sd1000;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    drain();
    check("ignored_tbl", int'(u_dut.u_table.q[5][3]), 0);
    for (int k = 0; k < 8; k++)
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 1)));
    drain();
    check("done_count", n_done, n_push);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
